// File: rtl/sram_axi_bridge_if.sv
// Bundle of the two SRAM-like core ports and the AXI3 master channels.
// The bridge connects through the master modport; the core/AXI-slave side uses slave.
interface sram_axi_bridge_if;
  // instruction SRAM-like port
  logic        inst_sram_req;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  // data SRAM-like port
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  // AXI read address
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // AXI read data
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // AXI write address
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  // AXI write data
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // AXI write response
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_sram_req, inst_sram_size, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
    input  data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output inst_sram_req, inst_sram_size, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
    output data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// Merges the IF (read-only) and MEM SRAM-like ports onto one AXI3 master.
// Reads share the AR channel (data has priority), responses are routed by rid.
//
// state   | meaning
// AR_IDLE | AR channel free, one read may be accepted this cycle
// AR_SEND | arvalid held with registered payload until arready
// W_IDLE  | no write in flight, data port may accept a write
// W_SEND  | awvalid and/or wvalid still waiting for its ready
// W_RESP  | both write handshakes done, waiting for bvalid
module sram_axi_bridge (
  input  logic              clk,
  input  logic              resetn,
  sram_axi_bridge_if.master io_bus
);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  ar_state_t   r_ar_state, w_ar_next;
  w_state_t    r_w_state, w_w_next;
  logic        r_inst_busy, r_data_busy;
  logic [3:0]  r_arid;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic [31:0] r_awaddr;
  logic [2:0]  r_awsize;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awvalid, r_wvalid;

  logic w_inst_rd_ok, w_data_rd_ok, w_data_b_ok, w_data_ok;
  logic w_inst_busy, w_data_busy;
  logic w_ar_idle, w_w_idle;
  logic w_inst_acc, w_data_rd_acc, w_data_wr_acc, w_data_acc;
  logic w_aw_pend, w_w_pend;
  logic w_unused;

  // Responses are gated by resetn so nothing completes during a reset cycle.
  assign w_inst_rd_ok = resetn & io_bus.rvalid & (io_bus.rid == ID_INST);
  assign w_data_rd_ok = resetn & io_bus.rvalid & (io_bus.rid == ID_DATA);
  assign w_data_b_ok  = resetn & io_bus.bvalid;
  assign w_data_ok    = w_data_rd_ok | w_data_b_ok;

  // A response in this cycle frees the port, so a new request can be taken at once.
  assign w_inst_busy = r_inst_busy & ~w_inst_rd_ok;
  assign w_data_busy = r_data_busy & ~w_data_ok;

  assign w_ar_idle = (r_ar_state == AR_IDLE);
  assign w_w_idle  = (r_w_state == W_IDLE);

  // Requiring W_IDLE keeps a data read from overtaking an unfinished write.
  assign w_data_rd_acc = resetn & io_bus.data_sram_req & ~io_bus.data_sram_wr
                         & w_ar_idle & ~w_data_busy & w_w_idle;
  assign w_data_wr_acc = resetn & io_bus.data_sram_req & io_bus.data_sram_wr
                         & w_w_idle & ~w_data_busy;
  assign w_inst_acc    = resetn & io_bus.inst_sram_req & w_ar_idle
                         & ~w_inst_busy & ~w_data_rd_acc;
  assign w_data_acc    = w_data_rd_acc | w_data_wr_acc;

  assign io_bus.inst_sram_addr_ok = w_inst_acc;
  assign io_bus.data_sram_addr_ok = w_data_acc;
  assign io_bus.inst_sram_data_ok = w_inst_rd_ok;
  assign io_bus.data_sram_data_ok = w_data_ok;
  assign io_bus.inst_sram_rdata   = io_bus.rdata;
  assign io_bus.data_sram_rdata   = io_bus.rdata;

  assign io_bus.arid    = r_arid;
  assign io_bus.araddr  = r_araddr;
  assign io_bus.arsize  = r_arsize;
  assign io_bus.arvalid = (r_ar_state == AR_SEND);
  assign io_bus.arlen   = 8'd0;
  assign io_bus.arburst = 2'b01;
  assign io_bus.arlock  = 2'b00;
  assign io_bus.arcache = 4'd0;
  assign io_bus.arprot  = 3'd0;
  assign io_bus.rready  = 1'b1;

  assign io_bus.awid    = ID_DATA;
  assign io_bus.awaddr  = r_awaddr;
  assign io_bus.awsize  = r_awsize;
  assign io_bus.awvalid = r_awvalid;
  assign io_bus.awlen   = 8'd0;
  assign io_bus.awburst = 2'b01;
  assign io_bus.awlock  = 2'b00;
  assign io_bus.awcache = 4'd0;
  assign io_bus.awprot  = 3'd0;
  assign io_bus.wid     = ID_DATA;
  assign io_bus.wdata   = r_wdata;
  assign io_bus.wstrb   = r_wstrb;
  assign io_bus.wlast   = 1'b1;
  assign io_bus.wvalid  = r_wvalid;
  assign io_bus.bready  = 1'b1;

  // Response status, burst end and write id carry no information for single beats.
  assign w_unused = ^{io_bus.rresp, io_bus.rlast, io_bus.bid, io_bus.bresp};

  // Outstanding flags: set on accept, clear on the matching data_ok.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_inst_busy <= 1'b0;
      r_data_busy <= 1'b0;
    end else begin
      r_inst_busy <= w_inst_acc | w_inst_busy;
      r_data_busy <= w_data_acc | w_data_busy;
    end
  end

  // State registers for both FSMs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ar_state <= AR_IDLE;
      r_w_state  <= W_IDLE;
    end else begin
      r_ar_state <= w_ar_next;
      r_w_state  <= w_w_next;
    end
  end

  // Read address next state: one accept per idle cycle, hold until arready.
  always_comb begin
    w_ar_next = r_ar_state;
    case (r_ar_state)
      AR_IDLE: if (w_inst_acc | w_data_rd_acc) w_ar_next = AR_SEND;
      AR_SEND: if (io_bus.arready)             w_ar_next = AR_IDLE;
      default: w_ar_next = AR_IDLE;
    endcase
  end

  // Capture the winning read request's payload on accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_arid   <= 4'd0;
      r_araddr <= 32'd0;
      r_arsize <= 3'd0;
    end else if (w_data_rd_acc) begin
      r_arid   <= ID_DATA;
      r_araddr <= io_bus.data_sram_addr;
      r_arsize <= {1'b0, io_bus.data_sram_size};
    end else if (w_inst_acc) begin
      r_arid   <= ID_INST;
      r_araddr <= io_bus.inst_sram_addr;
      r_arsize <= {1'b0, io_bus.inst_sram_size};
    end
  end

  assign w_aw_pend = r_awvalid & ~io_bus.awready;
  assign w_w_pend  = r_wvalid  & ~io_bus.wready;

  // Write next state: leave W_SEND once neither channel is still pending.
  always_comb begin
    w_w_next = r_w_state;
    case (r_w_state)
      W_IDLE: if (w_data_wr_acc)             w_w_next = W_SEND;
      W_SEND: if (!w_aw_pend && !w_w_pend)   w_w_next = W_RESP;
      W_RESP: if (io_bus.bvalid)             w_w_next = W_IDLE;
      default: w_w_next = W_IDLE;
    endcase
  end

  // Write payload and per-channel valids; each valid drops on its own ready.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_awaddr  <= 32'd0;
      r_awsize  <= 3'd0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'd0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
    end else if (w_data_wr_acc) begin
      r_awaddr  <= io_bus.data_sram_addr;
      r_awsize  <= {1'b0, io_bus.data_sram_size};
      r_wdata   <= io_bus.data_sram_wdata;
      r_wstrb   <= io_bus.data_sram_wstrb;
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
    end else begin
      if (io_bus.awready) r_awvalid <= 1'b0;
      if (io_bus.wready)  r_wvalid  <= 1'b0;
    end
  end

  // data_busy allows only one data transaction, so a data read return and a
  // write response can never legally coincide.
  a_no_rd_b_collide: assert property (@(posedge clk) disable iff (!resetn)
    !(io_bus.rvalid && io_bus.rid == ID_DATA && io_bus.bvalid));

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge; the bench plays both the core and the AXI slave.
module tb_sram_axi_bridge;
  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_data_q[$];
  int          exp_wr_q[$];
  logic [31:0] exp;

  sram_axi_bridge_if bus ();

  sram_axi_bridge dut (
    .clk   (clk),
    .resetn(resetn),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.inst_sram_req   = 1'b0;
    bus.inst_sram_size  = 2'd2;
    bus.inst_sram_addr  = 32'd0;
    bus.data_sram_req   = 1'b0;
    bus.data_sram_wr    = 1'b0;
    bus.data_sram_size  = 2'd2;
    bus.data_sram_wstrb = 4'd0;
    bus.data_sram_addr  = 32'd0;
    bus.data_sram_wdata = 32'd0;
    bus.arready = 1'b0;
    bus.rid     = 4'd0;
    bus.rdata   = 32'd0;
    bus.rresp   = 2'd0;
    bus.rlast   = 1'b1;
    bus.rvalid  = 1'b0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bid     = 4'd1;
    bus.bresp   = 2'd0;
    bus.bvalid  = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    bus.inst_sram_req = 1'b1;
    bus.data_sram_req = 1'b1;
    bus.rvalid = 1'b1;
    bus.bvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.arvalid, bus.awvalid, bus.wvalid} !== 3'b000) begin
      errors++; $display("FAIL reset valids: got %b want 000", {bus.arvalid, bus.awvalid, bus.wvalid});
    end
    checks++;
    if ({bus.inst_sram_addr_ok, bus.data_sram_addr_ok, bus.inst_sram_data_ok, bus.data_sram_data_ok} !== 4'b0000) begin
      errors++; $display("FAIL reset handshakes: got %b want 0000",
        {bus.inst_sram_addr_ok, bus.data_sram_addr_ok, bus.inst_sram_data_ok, bus.data_sram_data_ok});
    end
    checks++;
    if ({bus.rready, bus.bready, bus.arlen, bus.arburst, bus.awid, bus.wid, bus.wlast} !== {1'b1, 1'b1, 8'd0, 2'b01, 4'd1, 4'd1, 1'b1}) begin
      errors++; $display("FAIL reset constants: got rready=%b bready=%b arlen=%h arburst=%b awid=%h wid=%h wlast=%b",
        bus.rready, bus.bready, bus.arlen, bus.arburst, bus.awid, bus.wid, bus.wlast);
    end
    @(negedge clk);
    clear_inputs();
    resetn = 1'b1;
  endtask

  task automatic test_inst_read();
    // T: request accepted
    @(negedge clk);
    bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1C00_0000; bus.inst_sram_size = 2'd2;
    #1;
    checks++;
    if ({bus.inst_sram_addr_ok, bus.data_sram_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL inst_rd addr_ok: got %b want 10", {bus.inst_sram_addr_ok, bus.data_sram_addr_ok});
    end
    if (bus.inst_sram_addr_ok) exp_inst_q.push_back(32'h0280_0000);
    // T+1: AR issued
    @(negedge clk);
    bus.inst_sram_req = 1'b0; bus.arready = 1'b1;
    #1;
    checks++;
    if ({bus.arvalid, bus.arid, bus.araddr, bus.arsize} !== {1'b1, 4'd0, 32'h1C00_0000, 3'd2}) begin
      errors++; $display("FAIL inst_rd ar: got v=%b id=%h addr=%h size=%h want v=1 id=0 addr=1c000000 size=2",
        bus.arvalid, bus.arid, bus.araddr, bus.arsize);
    end
    @(negedge clk);
    bus.arready = 1'b0;
    #1;
    checks++;
    if (bus.arvalid !== 1'b0) begin
      errors++; $display("FAIL inst_rd ar_drop: got %b want 0", bus.arvalid);
    end
    // T+3: read data returns
    @(negedge clk);
    bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h0280_0000;
    #1;
    exp = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : 32'hxxxx_xxxx;
    checks++;
    if ({bus.inst_sram_data_ok, bus.data_sram_data_ok, bus.inst_sram_rdata} !== {2'b10, exp}) begin
      errors++; $display("FAIL inst_rd data: got ok=%b%b rdata=%h want ok=10 rdata=%h",
        bus.inst_sram_data_ok, bus.data_sram_data_ok, bus.inst_sram_rdata, exp);
    end
    @(negedge clk);
    bus.rvalid = 1'b0;
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h0000_1000;
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b0; bus.data_sram_addr = 32'h0000_2000; bus.data_sram_size = 2'd1;
    #1;
    checks++;
    if ({bus.data_sram_addr_ok, bus.inst_sram_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL arb grant: got data=%b inst=%b want data=1 inst=0", bus.data_sram_addr_ok, bus.inst_sram_addr_ok);
    end
    if (bus.data_sram_addr_ok) exp_data_q.push_back(32'hD0D0_2000);
    @(negedge clk);
    bus.data_sram_req = 1'b0; bus.arready = 1'b1;
    #1;
    checks++;
    if ({bus.arvalid, bus.arid, bus.araddr, bus.arsize, bus.inst_sram_addr_ok} !== {1'b1, 4'd1, 32'h0000_2000, 3'd1, 1'b0}) begin
      errors++; $display("FAIL arb first_ar: got v=%b id=%h addr=%h size=%h inst_ok=%b want v=1 id=1 addr=2000 size=1 inst_ok=0",
        bus.arvalid, bus.arid, bus.araddr, bus.arsize, bus.inst_sram_addr_ok);
    end
    @(negedge clk);
    bus.arready = 1'b0;
    #1;
    checks++;
    if (bus.inst_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL arb inst_later: got %b want 1", bus.inst_sram_addr_ok);
    end
    if (bus.inst_sram_addr_ok) exp_inst_q.push_back(32'h1111_1000);
    @(negedge clk);
    bus.inst_sram_req = 1'b0; bus.arready = 1'b1;
    #1;
    checks++;
    if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 4'd0, 32'h0000_1000}) begin
      errors++; $display("FAIL arb second_ar: got v=%b id=%h addr=%h want v=1 id=0 addr=1000", bus.arvalid, bus.arid, bus.araddr);
    end
    // inst data comes back before the older data read
    @(negedge clk);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h1111_1000;
    #1;
    exp = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : 32'hxxxx_xxxx;
    checks++;
    if ({bus.inst_sram_data_ok, bus.data_sram_data_ok, bus.inst_sram_rdata} !== {2'b10, exp}) begin
      errors++; $display("FAIL arb ooo_inst: got ok=%b%b rdata=%h want ok=10 rdata=%h",
        bus.inst_sram_data_ok, bus.data_sram_data_ok, bus.inst_sram_rdata, exp);
    end
    @(negedge clk);
    bus.rid = 4'd1; bus.rdata = 32'hD0D0_2000;
    #1;
    exp = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 32'hxxxx_xxxx;
    checks++;
    if ({bus.inst_sram_data_ok, bus.data_sram_data_ok, bus.data_sram_rdata} !== {2'b01, exp}) begin
      errors++; $display("FAIL arb ooo_data: got ok=%b%b rdata=%h want ok=01 rdata=%h",
        bus.inst_sram_data_ok, bus.data_sram_data_ok, bus.data_sram_rdata, exp);
    end
    @(negedge clk);
    bus.rvalid = 1'b0;
  endtask

  task automatic test_write();
    @(negedge clk);
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b1; bus.data_sram_addr = 32'h0000_0100;
    bus.data_sram_size = 2'd2; bus.data_sram_wstrb = 4'hF; bus.data_sram_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.data_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL wr addr_ok: got %b want 1", bus.data_sram_addr_ok);
    end
    if (bus.data_sram_addr_ok) exp_wr_q.push_back(1);
    @(negedge clk);
    bus.data_sram_req = 1'b0; bus.wready = 1'b1;
    #1;
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.awaddr, bus.awsize, bus.wdata, bus.wstrb} !== {2'b11, 32'h100, 3'd2, 32'hDEAD_BEEF, 4'hF}) begin
      errors++; $display("FAIL wr payload: got aw=%b w=%b addr=%h size=%h data=%h strb=%h want aw=1 w=1 addr=100 size=2 data=deadbeef strb=f",
        bus.awvalid, bus.wvalid, bus.awaddr, bus.awsize, bus.wdata, bus.wstrb);
    end
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk);
      bus.wready = 1'b0;
      bus.awready = (i == 3);
      #1;
      checks++;
      if ({bus.awvalid, bus.wvalid, bus.data_sram_data_ok} !== 3'b100) begin
        errors++; $display("FAIL wr hold cyc%0d: got aw=%b w=%b ok=%b want aw=1 w=0 ok=0", i, bus.awvalid, bus.wvalid, bus.data_sram_data_ok);
      end
    end
    @(negedge clk);
    bus.awready = 1'b0;
    #1;
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.data_sram_data_ok} !== 3'b000) begin
      errors++; $display("FAIL wr wait_b: got aw=%b w=%b ok=%b want 000", bus.awvalid, bus.wvalid, bus.data_sram_data_ok);
    end
    @(negedge clk);
    bus.bvalid = 1'b1;
    #1;
    checks++;
    if ({bus.data_sram_data_ok, bus.inst_sram_data_ok, exp_wr_q.size() == 1} !== 3'b101) begin
      errors++; $display("FAIL wr bresp: got data_ok=%b inst_ok=%b pending=%0d want 1 0 1",
        bus.data_sram_data_ok, bus.inst_sram_data_ok, exp_wr_q.size());
    end
    if (bus.data_sram_data_ok && exp_wr_q.size() > 0) void'(exp_wr_q.pop_front());
    @(negedge clk);
    bus.bvalid = 1'b0;
  endtask

  task automatic test_write_then_read();
    @(negedge clk);
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b1; bus.data_sram_addr = 32'h0000_0104;
    bus.data_sram_wstrb = 4'h3; bus.data_sram_wdata = 32'h0000_CAFE;
    #1;
    checks++;
    if (bus.data_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL wr_rd wr_accept: got %b want 1", bus.data_sram_addr_ok);
    end
    if (bus.data_sram_addr_ok) exp_wr_q.push_back(2);
    // switch to a read while the write is still in flight; AW and W complete together
    @(negedge clk);
    bus.data_sram_wr = 1'b0; bus.data_sram_addr = 32'h0000_0200; bus.awready = 1'b1; bus.wready = 1'b1;
    #1;
    checks++;
    if (bus.data_sram_addr_ok !== 1'b0) begin
      errors++; $display("FAIL wr_rd blocked_send: got %b want 0", bus.data_sram_addr_ok);
    end
    @(negedge clk);
    bus.awready = 1'b0; bus.wready = 1'b0;
    #1;
    checks++;
    if ({bus.data_sram_addr_ok, bus.awvalid, bus.wvalid, bus.data_sram_data_ok} !== 4'b0000) begin
      errors++; $display("FAIL wr_rd blocked_resp: got addr_ok=%b aw=%b w=%b ok=%b want 0000",
        bus.data_sram_addr_ok, bus.awvalid, bus.wvalid, bus.data_sram_data_ok);
    end
    @(negedge clk);
    bus.bvalid = 1'b1;
    #1;
    checks++;
    if ({bus.data_sram_data_ok, bus.data_sram_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL wr_rd bvalid_cyc: got data_ok=%b addr_ok=%b want 1 0", bus.data_sram_data_ok, bus.data_sram_addr_ok);
    end
    if (bus.data_sram_data_ok && exp_wr_q.size() > 0) void'(exp_wr_q.pop_front());
    @(negedge clk);
    bus.bvalid = 1'b0;
    #1;
    checks++;
    if (bus.data_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL wr_rd rd_accept: got %b want 1", bus.data_sram_addr_ok);
    end
    if (bus.data_sram_addr_ok) exp_data_q.push_back(32'h2222_0200);
    @(negedge clk);
    bus.data_sram_req = 1'b0; bus.arready = 1'b1;
    #1;
    checks++;
    if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 4'd1, 32'h0000_0200}) begin
      errors++; $display("FAIL wr_rd ar: got v=%b id=%h addr=%h want v=1 id=1 addr=200", bus.arvalid, bus.arid, bus.araddr);
    end
    @(negedge clk);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h2222_0200;
    #1;
    exp = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 32'hxxxx_xxxx;
    checks++;
    if ({bus.data_sram_data_ok, bus.data_sram_rdata} !== {1'b1, exp}) begin
      errors++; $display("FAIL wr_rd rdata: got ok=%b rdata=%h want ok=1 rdata=%h", bus.data_sram_data_ok, bus.data_sram_rdata, exp);
    end
    @(negedge clk);
    bus.rvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h0000_3000;
    #1;
    checks++;
    if (bus.inst_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL b2b first_accept: got %b want 1", bus.inst_sram_addr_ok);
    end
    if (bus.inst_sram_addr_ok) exp_inst_q.push_back(32'h3333_3000);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      bus.inst_sram_addr = 32'h0000_3004;
      bus.arready = (i == 6);
      #1;
      checks++;
      if ({bus.arvalid, bus.araddr, bus.inst_sram_addr_ok} !== {1'b1, 32'h0000_3000, 1'b0}) begin
        errors++; $display("FAIL b2b stall cyc%0d: got v=%b addr=%h addr_ok=%b want v=1 addr=3000 addr_ok=0",
          i, bus.arvalid, bus.araddr, bus.inst_sram_addr_ok);
      end
    end
    @(negedge clk);
    bus.arready = 1'b0;
    #1;
    checks++;
    if ({bus.arvalid, bus.inst_sram_addr_ok} !== 2'b00) begin
      errors++; $display("FAIL b2b busy: got v=%b addr_ok=%b want 00", bus.arvalid, bus.inst_sram_addr_ok);
    end
    @(negedge clk);
    bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h3333_3000;
    #1;
    exp = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : 32'hxxxx_xxxx;
    checks++;
    if ({bus.inst_sram_data_ok, bus.inst_sram_rdata, bus.inst_sram_addr_ok} !== {1'b1, exp, 1'b1}) begin
      errors++; $display("FAIL b2b data_and_accept: got ok=%b rdata=%h addr_ok=%b want ok=1 rdata=%h addr_ok=1",
        bus.inst_sram_data_ok, bus.inst_sram_rdata, bus.inst_sram_addr_ok, exp);
    end
    if (bus.inst_sram_addr_ok) exp_inst_q.push_back(32'h3333_3004);
    @(negedge clk);
    bus.rvalid = 1'b0; bus.inst_sram_req = 1'b0; bus.arready = 1'b1;
    #1;
    checks++;
    if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 4'd0, 32'h0000_3004}) begin
      errors++; $display("FAIL b2b second_ar: got v=%b id=%h addr=%h want v=1 id=0 addr=3004", bus.arvalid, bus.arid, bus.araddr);
    end
    @(negedge clk);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h3333_3004;
    #1;
    exp = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : 32'hxxxx_xxxx;
    checks++;
    if ({bus.inst_sram_data_ok, bus.inst_sram_rdata} !== {1'b1, exp}) begin
      errors++; $display("FAIL b2b second_data: got ok=%b rdata=%h want ok=1 rdata=%h", bus.inst_sram_data_ok, bus.inst_sram_rdata, exp);
    end
    @(negedge clk);
    bus.rvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b1; bus.data_sram_addr = 32'h0000_0300; bus.data_sram_wdata = 32'h1234_5678;
    #1;
    checks++;
    if (bus.data_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL rst_mid wr_accept: got %b want 1", bus.data_sram_addr_ok);
    end
    @(negedge clk);
    bus.data_sram_req = 1'b0; bus.awready = 1'b1; bus.wready = 1'b1;
    bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h0000_4000;
    #1;
    checks++;
    if (bus.inst_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL rst_mid inst_accept: got %b want 1", bus.inst_sram_addr_ok);
    end
    // AR_SEND and W_RESP both active; reset with a data read pending at the port
    @(negedge clk);
    bus.awready = 1'b0; bus.wready = 1'b0; bus.inst_sram_req = 1'b0;
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b0; bus.data_sram_addr = 32'h0000_5000;
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.data_sram_addr_ok} !== 4'b1000) begin
      errors++; $display("FAIL rst_mid before: got ar=%b aw=%b w=%b addr_ok=%b want 1000",
        bus.arvalid, bus.awvalid, bus.wvalid, bus.data_sram_addr_ok);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.data_sram_addr_ok} !== 4'b0001) begin
      errors++; $display("FAIL rst_mid after: got ar=%b aw=%b w=%b addr_ok=%b want 0001",
        bus.arvalid, bus.awvalid, bus.wvalid, bus.data_sram_addr_ok);
    end
    if (bus.data_sram_addr_ok) exp_data_q.push_back(32'h5555_5000);
    @(negedge clk);
    bus.data_sram_req = 1'b0; bus.arready = 1'b1;
    #1;
    checks++;
    if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 4'd1, 32'h0000_5000}) begin
      errors++; $display("FAIL rst_mid ar: got v=%b id=%h addr=%h want v=1 id=1 addr=5000", bus.arvalid, bus.arid, bus.araddr);
    end
    @(negedge clk);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h5555_5000;
    #1;
    exp = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 32'hxxxx_xxxx;
    checks++;
    if ({bus.data_sram_data_ok, bus.data_sram_rdata} !== {1'b1, exp}) begin
      errors++; $display("FAIL rst_mid rdata: got ok=%b rdata=%h want ok=1 rdata=%h", bus.data_sram_data_ok, bus.data_sram_rdata, exp);
    end
    @(negedge clk);
    bus.rvalid = 1'b0;
  endtask

  task automatic test_drain();
    checks++;
    if ({exp_inst_q.size(), exp_data_q.size(), exp_wr_q.size()} != 96'd0) begin
      errors++; $display("FAIL drain: got inst=%0d data=%0d wr=%0d left want 0 0 0",
        exp_inst_q.size(), exp_data_q.size(), exp_wr_q.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_inst_read();
    test_arbitration();
    test_write();
    test_write_then_read();
    test_back_to_back();
    test_reset_mid();
    test_drain();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Converts the two SRAM-like request ports of the CPU core (instruction fetch, data access) onto a single AXI3 master interface. It arbitrates between them on the shared read address channel and routes read data back by ID. It sequences the write address, write data and write response channels for the data port. It sits between the core pipeline (IF/MEM stages) and the top-level AXI port.

## Interface
Parameters: none.
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- inst_sram_req  in  1  IF read request (read-only port)
- inst_sram_size  in  2  0:byte 1:half 2:word
- inst_sram_addr  in  32  fetch address
- inst_sram_addr_ok  out  1  request accepted this cycle
- inst_sram_data_ok  out  1  read data valid this cycle
- inst_sram_rdata  out  32  read data
- data_sram_req  in  1  MEM request
- data_sram_wr  in  1  1: write, 0: read
- data_sram_size  in  2  access size
- data_sram_wstrb  in  4  byte enables (write)
- data_sram_addr  in  32  address
- data_sram_wdata  in  32  write data
- data_sram_addr_ok  out  1  request accepted this cycle
- data_sram_data_ok  out  1  read data valid / write response this cycle
- data_sram_rdata  out  32  read data
- arid[3:0], araddr[31:0], arsize[2:0], arvalid  out; arready  in
- arlen[7:0]=0, arburst[1:0]=01, arlock[1:0]=0, arcache[3:0]=0, arprot[2:0]=0  out (constants)
- rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid  in; rready  out
- awid[3:0]=1, awaddr[31:0], awsize[2:0], awvalid  out; awready  in; awlen/awburst/awlock/awcache/awprot use the AR constants
- wid[3:0]=1, wdata[31:0], wstrb[3:0], wlast=1, wvalid  out; wready  in
- bid[3:0], bresp[1:0], bvalid  in; bready  out

## Operation
- Read-address FSM AR_IDLE/AR_SEND. In AR_IDLE, one read may be accepted per cycle. The accepted request's addr/size/ID are registered. Next state is AR_SEND with arvalid=1. AR_SEND returns to AR_IDLE on arready.
- Arbitration in AR_IDLE: a data read has fixed priority over an inst read. The inst request gets addr_ok only when no data read is eligible that cycle.
- IDs: inst arid=0, data arid=1. arsize={1'b0,size}.
- Outstanding limits: at most one outstanding inst read (inst_busy) and one outstanding data transaction of any kind (data_busy). A flag sets on addr_ok and clears on the matching data_ok.
- inst_sram_addr_ok = inst_req & AR_IDLE & ~inst_busy & ~(data read eligible).
- Data read eligible = data_req & ~wr & AR_IDLE & ~data_busy & write FSM in W_IDLE. No read bypasses a pending write.
- data write addr_ok = data_req & wr & W_IDLE & ~data_busy.
- Write FSM W_IDLE/W_SEND/W_RESP. On accept, awaddr/awsize/wdata/wstrb are registered and awvalid=wvalid=1.
  - Each valid drops independently on its own ready.
  - When both handshakes have completed, the FSM enters W_RESP and waits for bvalid, then returns to W_IDLE.
  - AW and W handshakes in the same cycle go straight to W_RESP.
- rready=1 and bready=1 always.
- On rvalid, rid selects the target port.
  - rid==0: inst_sram_data_ok=1.
  - rid==1: data_sram_data_ok=1.
  - rdata is passed combinationally to both rdata outputs.
- On bvalid, data_sram_data_ok=1.
- rresp/bresp are ignored.
- Every accepted request receives exactly one data_ok, with no cancellation. IF discards flushed fetches itself.

## Timing
- Reset (resetn=0 at a clock edge): arvalid=awvalid=wvalid=0, FSMs idle, inst_busy=data_busy=0, all addr_ok/data_ok=0. Reset mid-transaction abandons it; the AXI slave is reset together.
- addr_ok is combinational from req and state, in the same cycle. The request is sampled on that edge.
- AR/AW/W valid rises in the cycle after addr_ok and holds with stable payload until ready.
- data_ok is combinational, in the same cycle as rvalid/bvalid.
  - Minimum read latency is addr_ok T, arvalid T+1, rvalid T+2, data_ok T+2.
  - A new request on the same port may get addr_ok in that same cycle, since busy is cleared combinationally by data_ok.
- When rvalid(rid=1) and bvalid arrive in the same cycle, the write response is not possible because data_busy forbids it. An assertion flags it.
- Simultaneous inst and data read requests: data wins. Inst waits at least until AR returns to idle.

## Test plan
- Single inst read 0x1C000000: addr_ok T, arvalid/araddr=0x1C000000, arid=0 at T+1; slave rvalid rid=0 rdata=0x02800000 at T+3 → inst_sram_data_ok=1, rdata=0x02800000 at T+3.
- Simultaneous inst and data read in the same cycle: data_addr_ok=1, inst_addr_ok=0. The first AR has arid=1 and the next has arid=0. Out-of-order returns (rid 0 first) route to the correct ports.
- Data write addr 0x100, wstrb=0xF, wdata=0xDEADBEEF, with awready delayed 3 cycles and wready immediate: wvalid drops after 1 cycle, awvalid holds 3. data_ok only on bvalid.
- Write followed by data read: the read's addr_ok is held low until the write's bvalid cycle, then the read is accepted.
- Back-to-back inst reads, arready held low 5 cycles: araddr stable, no second addr_ok until first data_ok.
- resetn low while AR_SEND and W_RESP are active: the next cycle has all valids 0, the FSMs idle, and a new req accepted immediately.
